// File: rtl/alarm_tone_gen_if.sv
// alarm_tone_gen_if
// Groups the water-level alarm signals between the level-measurement side
// and the alarm driver.
//   water_level_int : unsigned water level (LEVEL_W bits), driven by master
//   ack             : mute request, driven by master
//   Beep            : buzzer drive, driven by slave
//   tier            : 0=SAFE 1=WARN 2=ALERT 3=CRITICAL, driven by slave
//   muted           : alarm acknowledged, tone suppressed, driven by slave
// Modports: master (level source / display side), slave (alarm_tone_gen).
interface alarm_tone_gen_if #(
    parameter int LEVEL_W = 4
);
    logic [LEVEL_W-1:0] water_level_int;
    logic               ack;
    logic               Beep;
    logic [1:0]         tier;
    logic               muted;

    modport master (
        output water_level_int,
        output ack,
        input  Beep,
        input  tier,
        input  muted
    );

    modport slave (
        input  water_level_int,
        input  ack,
        output Beep,
        output tier,
        output muted
    );
endinterface

// File: rtl/alarm_tone_gen.sv
// alarm_tone_gen
// Multi-tier audible alarm driver. Classifies the water level into
// SAFE/WARN/ALERT/CRITICAL with de-escalation hysteresis, generates a
// per-tier square-wave tone on Beep, and supports an operator mute that
// re-arms on escalation or on return to SAFE.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : alarm_tone_gen_if.slave (water_level_int, ack in; Beep, tier, muted out)
// Optional feature macro: ALARM_CADENCE_EN -- when defined, the CRITICAL tone
// is gated on/off in CADENCE_CYC-cycle halves; otherwise it is continuous.
module alarm_tone_gen #(
    parameter int CLK_HZ      = 1000,
    parameter int LEVEL_W     = 4,
    parameter int T1          = 7,
    parameter int T2          = 11,
    parameter int T3          = 15,
    parameter int HYST        = 1,
    parameter int F1          = 50,
    parameter int F2          = 125,
    parameter int F3          = 250,
    parameter int CADENCE_CYC = 8
) (
    input  logic              clk,
    input  logic              rst,
    alarm_tone_gen_if.slave   bus
);

`ifdef ALARM_CADENCE_EN
    localparam bit CADENCE_EN = 1'b1;
`else
    localparam bit CADENCE_EN = 1'b0;
`endif

    // Half-periods of each tier tone in clock cycles.
    localparam int HALF1 = CLK_HZ / (2 * F1);
    localparam int HALF2 = CLK_HZ / (2 * F2);
    localparam int HALF3 = CLK_HZ / (2 * F3);

    // WARN has the lowest frequency, so its half-period bounds the counter.
    localparam int CNT_W = (HALF1 > 1) ? $clog2(HALF1) : 1;
    localparam int CAD_W = (CADENCE_CYC > 1) ? $clog2(CADENCE_CYC) : 1;

    localparam logic [CNT_W-1:0] HALF1_M1 = CNT_W'(HALF1 - 1);
    localparam logic [CNT_W-1:0] HALF2_M1 = CNT_W'(HALF2 - 1);
    localparam logic [CNT_W-1:0] HALF3_M1 = CNT_W'(HALF3 - 1);
    localparam logic [CAD_W-1:0] CAD_LAST = CAD_W'(CADENCE_CYC - 1);

    // Escalation thresholds.
    localparam logic [LEVEL_W-1:0] T1_L = LEVEL_W'(T1);
    localparam logic [LEVEL_W-1:0] T2_L = LEVEL_W'(T2);
    localparam logic [LEVEL_W-1:0] T3_L = LEVEL_W'(T3);

    // De-escalation thresholds (Tk - HYST, saturating at 0).
    localparam logic [LEVEL_W-1:0] H1_L = LEVEL_W'((T1 > HYST) ? (T1 - HYST) : 0);
    localparam logic [LEVEL_W-1:0] H2_L = LEVEL_W'((T2 > HYST) ? (T2 - HYST) : 0);
    localparam logic [LEVEL_W-1:0] H3_L = LEVEL_W'((T3 > HYST) ? (T3 - HYST) : 0);

    typedef enum logic [1:0] {
        SAFE     = 2'd0,
        WARN     = 2'd1,
        ALERT    = 2'd2,
        CRITICAL = 2'd3
    } tier_t;

    tier_t              tier_reg, tier_next, raw_tier;
    logic               escalate;
    logic               muted_reg, muted_next;
    logic               beep_reg, beep_next;
    logic [CNT_W-1:0]   phase_reg, phase_next, half_m1;
    logic [CAD_W-1:0]   cad_reg, cad_next;
    logic               cad_off_reg, cad_off_next;

    logic [LEVEL_W-1:0] level;
    assign level = bus.water_level_int;

    // Raw tier: number of escalation thresholds the level meets.
    always_comb begin
        raw_tier = SAFE;
        if (level >= T3_L) begin
            raw_tier = CRITICAL;
        end else if (level >= T2_L) begin
            raw_tier = ALERT;
        end else if (level >= T1_L) begin
            raw_tier = WARN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tier_reg    <= SAFE;
            muted_reg   <= 1'b0;
            beep_reg    <= 1'b0;
            phase_reg   <= '0;
            cad_reg     <= '0;
            cad_off_reg <= 1'b0;
        end else begin
            tier_reg    <= tier_next;
            muted_reg   <= muted_next;
            beep_reg    <= beep_next;
            phase_reg   <= phase_next;
            cad_reg     <= cad_next;
            cad_off_reg <= cad_off_next;
        end
    end

    always_comb begin
        escalate     = (raw_tier > tier_reg);
        tier_next    = tier_reg;
        muted_next   = muted_reg;
        cad_next     = cad_reg;
        cad_off_next = cad_off_reg;
        phase_next   = phase_reg + 1'b1;
        beep_next    = beep_reg;
        half_m1      = HALF1_M1;

        // Tier: jump straight up to raw; otherwise fall to the highest tier
        // not above the current one whose hysteresis threshold is still met.
        // The ifs run in ascending order so the highest satisfied one wins.
        if (escalate) begin
            tier_next = raw_tier;
        end else begin
            tier_next = SAFE;
            if (tier_reg >= WARN && level >= H1_L) begin
                tier_next = WARN;
            end
            if (tier_reg >= ALERT && level >= H2_L) begin
                tier_next = ALERT;
            end
            if (tier_reg == CRITICAL && level >= H3_L) begin
                tier_next = CRITICAL;
            end
        end

        // Mute: escalation or return to SAFE re-arms, and takes priority
        // over a simultaneous ack.
        if (escalate || tier_next == SAFE) begin
            muted_next = 1'b0;
        end else if (bus.ack && tier_reg != SAFE) begin
            muted_next = 1'b1;
        end

        // Cadence: restarts in the on phase whenever CRITICAL is entered.
        if (!CADENCE_EN || tier_next != CRITICAL || tier_next != tier_reg) begin
            cad_next     = '0;
            cad_off_next = 1'b0;
        end else if (cad_reg == CAD_LAST) begin
            cad_next     = '0;
            cad_off_next = ~cad_off_reg;
        end else begin
            cad_next = cad_reg + 1'b1;
        end

        case (tier_reg)
            ALERT:    half_m1 = HALF2_M1;
            CRITICAL: half_m1 = HALF3_M1;
            default:  half_m1 = HALF1_M1;
        endcase

        // Tone divider. The cycle leaving the off phase is also held, so
        // each on phase restarts with the same timing as a fresh tier entry.
        if (tier_next != tier_reg || tier_next == SAFE || muted_next ||
            cad_off_next || cad_off_reg) begin
            phase_next = '0;
            beep_next  = 1'b0;
        end else if (phase_reg == half_m1) begin
            phase_next = '0;
            beep_next  = ~beep_reg;
        end
    end

    assign bus.Beep  = beep_reg;
    assign bus.tier  = tier_reg;
    assign bus.muted = muted_reg;

endmodule

// File: tb/tb_alarm_tone_gen.sv
// tb_alarm_tone_gen
// Directed bench for alarm_tone_gen with default parameters
// (HALF1 = 10, HALF2 = 4, HALF3 = 2). Inputs change and outputs are sampled
// 1 time unit after each rising clock edge.
module tb_alarm_tone_gen;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic exp_beep;

    alarm_tone_gen_if #(.LEVEL_W(4)) bus ();

    alarm_tone_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.ack = 1'b0;
        bus.water_level_int = 4'd0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Reset values while held.
        rst = 1'b1;
        bus.ack = 1'b0;
        bus.water_level_int = 4'd0;
        tick();
        tick();
        vectors++;
        if (bus.Beep !== 1'b0 || bus.tier !== 2'd0 || bus.muted !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold Beep=%b tier=%0d muted=%b expected 0/0/0", bus.Beep, bus.tier, bus.muted);
        end
        rst = 1'b0;
        bus.water_level_int = 4'd12;
        for (int k = 0; k <= 4; k++) tick();
        // k=4 after entering ALERT: Beep high.
        vectors++;
        if (bus.tier !== 2'd2 || bus.Beep !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pre_tone tier=%0d Beep=%b expected 2/1", bus.tier, bus.Beep);
        end
        // Asynchronous reset mid-tone, away from the clock edge.
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.Beep !== 1'b0 || bus.tier !== 2'd0 || bus.muted !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async Beep=%b tier=%0d muted=%b expected 0/0/0", bus.Beep, bus.tier, bus.muted);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        vectors++;
        if (bus.tier !== 2'd2 || bus.Beep !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release tier=%0d Beep=%b expected 2/0", bus.tier, bus.Beep);
        end
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_beep = ((k / 4) % 2) != 0;
            vectors++;
            if (bus.Beep !== exp_beep) begin
                miscompares++;
                $display("FAIL reset_tone k=%0d Beep=%b expected %b", k, bus.Beep, exp_beep);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_tier_sweep();
        do_reset();
        tick();
        vectors++;
        if (bus.tier !== 2'd0 || bus.Beep !== 1'b0) begin
            miscompares++;
            $display("FAIL sweep_safe tier=%0d Beep=%b expected 0/0", bus.tier, bus.Beep);
        end
        bus.water_level_int = 4'd7;
        #3;
        vectors++;
        if (bus.tier !== 2'd0) begin
            miscompares++;
            $display("FAIL sweep_latency tier=%0d expected 0", bus.tier);
        end
        tick();
        vectors++;
        if (bus.tier !== 2'd1 || bus.Beep !== 1'b0) begin
            miscompares++;
            $display("FAIL sweep_warn tier=%0d Beep=%b expected 1/0", bus.tier, bus.Beep);
        end
        for (int k = 1; k <= 15; k++) begin
            tick();
            exp_beep = ((k / 10) % 2) != 0;
            vectors++;
            if (bus.Beep !== exp_beep) begin
                miscompares++;
                $display("FAIL sweep_warn_tone k=%0d Beep=%b expected %b", k, bus.Beep, exp_beep);
            end
        end
        bus.water_level_int = 4'd11;
        tick();
        vectors++;
        if (bus.tier !== 2'd2 || bus.Beep !== 1'b0) begin
            miscompares++;
            $display("FAIL sweep_alert tier=%0d Beep=%b expected 2/0", bus.tier, bus.Beep);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_beep = ((k / 4) % 2) != 0;
            vectors++;
            if (bus.Beep !== exp_beep) begin
                miscompares++;
                $display("FAIL sweep_alert_tone k=%0d Beep=%b expected %b", k, bus.Beep, exp_beep);
            end
        end
        bus.water_level_int = 4'd15;
        tick();
        vectors++;
        if (bus.tier !== 2'd3 || bus.Beep !== 1'b0) begin
            miscompares++;
            $display("FAIL sweep_crit tier=%0d Beep=%b expected 3/0", bus.tier, bus.Beep);
        end
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_beep = ((k / 2) % 2) != 0;
            vectors++;
            if (bus.Beep !== exp_beep) begin
                miscompares++;
                $display("FAIL sweep_crit_tone k=%0d Beep=%b expected %b", k, bus.Beep, exp_beep);
            end
        end
        $display("test_tier_sweep done");
    endtask

    task automatic test_hysteresis();
        do_reset();
        bus.water_level_int = 4'd11;
        tick();
        bus.water_level_int = 4'd10;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (bus.tier !== 2'd2) begin
                miscompares++;
                $display("FAIL hyst_hold10 k=%0d tier=%0d expected 2", k, bus.tier);
            end
        end
        bus.water_level_int = 4'd9;
        tick();
        vectors++;
        if (bus.tier !== 2'd1) begin
            miscompares++;
            $display("FAIL hyst_drop9 tier=%0d expected 1", bus.tier);
        end
        bus.water_level_int = 4'd11;
        tick();
        for (int k = 1; k <= 8; k++) begin
            bus.water_level_int = (k % 2 != 0) ? 4'd10 : 4'd11;
            tick();
            exp_beep = ((k / 4) % 2) != 0;
            vectors++;
            if (bus.tier !== 2'd2 || bus.Beep !== exp_beep) begin
                miscompares++;
                $display("FAIL hyst_toggle k=%0d tier=%0d Beep=%b expected 2/%b", k, bus.tier, bus.Beep, exp_beep);
            end
        end
        $display("test_hysteresis done");
    endtask

    task automatic test_jump();
        do_reset();
        bus.water_level_int = 4'd15;
        for (int k = 0; k <= 3; k++) tick();
        vectors++;
        if (bus.tier !== 2'd3 || bus.Beep !== 1'b1) begin
            miscompares++;
            $display("FAIL jump_pre tier=%0d Beep=%b expected 3/1", bus.tier, bus.Beep);
        end
        bus.water_level_int = 4'd0;
        tick();
        vectors++;
        if (bus.tier !== 2'd0 || bus.Beep !== 1'b0) begin
            miscompares++;
            $display("FAIL jump_drop tier=%0d Beep=%b expected 0/0", bus.tier, bus.Beep);
        end
        $display("test_jump done");
    endtask

    task automatic test_mute();
        do_reset();
        bus.water_level_int = 4'd7;
        for (int k = 0; k <= 10; k++) tick();
        vectors++;
        if (bus.tier !== 2'd1 || bus.Beep !== 1'b1 || bus.muted !== 1'b0) begin
            miscompares++;
            $display("FAIL mute_pre tier=%0d Beep=%b muted=%b expected 1/1/0", bus.tier, bus.Beep, bus.muted);
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        vectors++;
        if (bus.muted !== 1'b1 || bus.Beep !== 1'b0) begin
            miscompares++;
            $display("FAIL mute_set muted=%b Beep=%b expected 1/0", bus.muted, bus.Beep);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            vectors++;
            if (bus.muted !== 1'b1 || bus.Beep !== 1'b0) begin
                miscompares++;
                $display("FAIL mute_hold k=%0d muted=%b Beep=%b expected 1/0", k, bus.muted, bus.Beep);
            end
        end
        bus.water_level_int = 4'd11;
        tick();
        vectors++;
        if (bus.tier !== 2'd2 || bus.muted !== 1'b0 || bus.Beep !== 1'b0) begin
            miscompares++;
            $display("FAIL mute_rearm tier=%0d muted=%b Beep=%b expected 2/0/0", bus.tier, bus.muted, bus.Beep);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_beep = ((k / 4) % 2) != 0;
            vectors++;
            if (bus.Beep !== exp_beep) begin
                miscompares++;
                $display("FAIL mute_resume k=%0d Beep=%b expected %b", k, bus.Beep, exp_beep);
            end
        end
        // ack together with escalation: escalation wins.
        bus.ack = 1'b1;
        bus.water_level_int = 4'd15;
        tick();
        bus.ack = 1'b0;
        vectors++;
        if (bus.tier !== 2'd3 || bus.muted !== 1'b0) begin
            miscompares++;
            $display("FAIL mute_ack_escalate tier=%0d muted=%b expected 3/0", bus.tier, bus.muted);
        end
        tick();
        tick();
        vectors++;
        if (bus.muted !== 1'b0 || bus.Beep !== 1'b1) begin
            miscompares++;
            $display("FAIL mute_crit_tone muted=%b Beep=%b expected 0/1", bus.muted, bus.Beep);
        end
        // Mute in CRITICAL, then de-escalate: stays muted.
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        bus.water_level_int = 4'd11;
        tick();
        vectors++;
        if (bus.tier !== 2'd2 || bus.muted !== 1'b1 || bus.Beep !== 1'b0) begin
            miscompares++;
            $display("FAIL mute_deesc tier=%0d muted=%b Beep=%b expected 2/1/0", bus.tier, bus.muted, bus.Beep);
        end
        bus.water_level_int = 4'd0;
        tick();
        vectors++;
        if (bus.tier !== 2'd0 || bus.muted !== 1'b0) begin
            miscompares++;
            $display("FAIL mute_safe_clear tier=%0d muted=%b expected 0/0", bus.tier, bus.muted);
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        vectors++;
        if (bus.muted !== 1'b0) begin
            miscompares++;
            $display("FAIL mute_ack_safe muted=%b expected 0", bus.muted);
        end
        $display("test_mute done");
    endtask

    task automatic test_cadence();
        int ph;
        do_reset();
        bus.water_level_int = 4'd15;
        tick();
        vectors++;
        if (bus.tier !== 2'd3 || bus.Beep !== 1'b0) begin
            miscompares++;
            $display("FAIL cad_entry tier=%0d Beep=%b expected 3/0", bus.tier, bus.Beep);
        end
        for (int k = 1; k <= 40; k++) begin
            tick();
`ifdef ALARM_CADENCE_EN
            ph = k % 16;
            exp_beep = (ph < 8) ? (((ph / 2) % 2) != 0) : 1'b0;
`else
            ph = k;
            exp_beep = ((ph / 2) % 2) != 0;
`endif
            vectors++;
            if (bus.Beep !== exp_beep) begin
                miscompares++;
                $display("FAIL cad_tone k=%0d Beep=%b expected %b", k, bus.Beep, exp_beep);
            end
        end
        $display("test_cadence done");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.ack     = 1'b0;
        bus.water_level_int = 4'd0;
        test_reset();
        test_tier_sweep();
        test_hysteresis();
        test_jump();
        test_mute();
        test_cadence();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
